// File: rtl/control_carga_if.sv
// rtl/control_carga_if.sv - operand-loader bus: switch/button inputs, ALU operands and registered results
interface control_carga_if #(
  parameter int b_dat = 8,
  parameter int b_op  = 6
) ();
  logic [b_dat-1:0] entrada;
  logic             boton;
  logic             cancelar;
  logic [b_dat-1:0] rdo_alu;
  logic             carry_alu;
  logic             zero_alu;
  logic [b_dat-1:0] a;
  logic [b_dat-1:0] b;
  logic [b_op-1:0]  op;
  logic [b_dat-1:0] rdo;
  logic             carry;
  logic             zero;
  logic             valido;
  logic [2:0]       estado;

  modport master (
    output entrada, boton, cancelar, rdo_alu, carry_alu, zero_alu,
    input  a, b, op, rdo, carry, zero, valido, estado
  );

  modport slave (
    input  entrada, boton, cancelar, rdo_alu, carry_alu, zero_alu,
    output a, b, op, rdo, carry, zero, valido, estado
  );
endinterface

// File: rtl/control_carga.sv
// rtl/control_carga.sv - debounced push-button loader sequencing A, B, OP into an ALU and latching its result
module control_carga #(
  parameter int b_dat      = 8,
  parameter int b_op       = 6,
  parameter int DEB_CICLOS = 4
) (
  input logic            clk,
  input logic            rst_n,
  control_carga_if.slave bus
);
  localparam int CW = $clog2(DEB_CICLOS + 1);

  typedef enum logic [2:0] {
    ESP_A   = 3'd0,
    ESP_B   = 3'd1,
    ESP_OP  = 3'd2,
    CALC    = 3'd3,
    MOSTRAR = 3'd4
  } estado_t;

  logic          sync1_q, sync2_q;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;

  estado_t          state_q, state_d;
  logic [b_dat-1:0] a_q, a_d, b_q, b_d, rdo_q, rdo_d;
  logic [b_op-1:0]  op_q, op_d;
  logic             carry_q, carry_d, zero_q, zero_d, valido_q, valido_d;

  // armed only once boton_s is seen low after the synchronizer has filled,
  // so a button held through reset never produces a strobe
  always_comb begin
    cnt_d = '0;
    if (sync2_q)
      cnt_d = (cnt_q == CW'(DEB_CICLOS)) ? cnt_q : cnt_q + CW'(1);
    pulso_d = armed_q && sync2_q && (cnt_q == CW'(DEB_CICLOS - 1));
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      sync1_q <= bus.boton;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rdo_d    = rdo_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    valido_d = valido_q;
    if (bus.cancelar) begin
      state_d  = ESP_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      rdo_d    = '0;
      carry_d  = 1'b0;
      zero_d   = 1'b0;
      valido_d = 1'b0;
    end else begin
      case (state_q)
        ESP_A: if (pulso_q) begin
          a_d     = bus.entrada;
          state_d = ESP_B;
        end
        ESP_B: if (pulso_q) begin
          b_d     = bus.entrada;
          state_d = ESP_OP;
        end
        ESP_OP: if (pulso_q) begin
          op_d    = b_op'(bus.entrada);
          state_d = CALC;
        end
        CALC: begin
          rdo_d    = bus.rdo_alu;
          carry_d  = bus.carry_alu;
          zero_d   = bus.zero_alu;
          valido_d = 1'b1;
          state_d  = MOSTRAR;
        end
        MOSTRAR: if (pulso_q) begin
          a_d      = bus.entrada;
          valido_d = 1'b0;
          state_d  = ESP_B;
        end
        default: state_d = ESP_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ESP_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rdo_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rdo_q    <= rdo_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      valido_q <= valido_d;
    end
  end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.op     = op_q;
  assign bus.rdo    = rdo_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.valido = valido_q;
  assign bus.estado = state_q;
endmodule

// File: tb/tb_control_carga.sv
// tb/tb_control_carga.sv - scoreboard bench for control_carga with an adder ALU model
module tb_control_carga;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;
  logic valido_prev = 1'b0;
  logic [9:0] exp_q[$];

  control_carga_if #(.b_dat(8), .b_op(6)) bus ();

  control_carga #(.b_dat(8), .b_op(6), .DEB_CICLOS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign {bus.carry_alu, bus.rdo_alu} = {1'b0, bus.a} + {1'b0, bus.b};
  assign bus.zero_alu = (bus.rdo_alu == 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pop an expected result on every rising edge of valido, count strobes
  always @(negedge clk) begin
    logic [9:0] e;
    if (bus.valido && !valido_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got valido with rdo=%0h expected no result", bus.rdo);
      end else begin
        e = exp_q.pop_front();
        check("sb_rdo", 32'(bus.rdo), 32'(e[9:2]));
        check("sb_carry", 32'(bus.carry), 32'(e[1]));
        check("sb_zero", 32'(bus.zero), 32'(e[0]));
      end
    end
    valido_prev = bus.valido;
    if (dut.pulso_q) pulse_cnt++;
  end

  task automatic press(input logic [7:0] val);
    @(posedge clk); #1;
    bus.entrada = val;
    bus.boton = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.boton = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic press_chk(input logic [7:0] val, input string name);
    int p0;
    p0 = pulse_cnt;
    press(val);
    check(name, 32'(pulse_cnt - p0), 32'd1);
  endtask

  task automatic cancel();
    @(posedge clk); #1 bus.cancelar = 1'b1;
    @(posedge clk); #1 bus.cancelar = 1'b0;
  endtask

  task automatic wait_pulso(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (dut.pulso_q) found = 1'b1;
    end
    if (!found) check("pulso_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit found;
    int p0;
    int edge_at;
    bus.entrada = 8'h00;
    bus.boton = 1'b0;
    bus.cancelar = 1'b0;
    #3;
    check("rst_estado", 32'(bus.estado), 32'd0);
    check("rst_valido", 32'(bus.valido), 32'd0);
    check("rst_a_b_op_rdo", {bus.a, bus.b, bus.op, 2'b0, bus.rdo}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // basic operation 5 + 3
    press_chk(8'h05, "pulse_a");
    check("load_a", 32'(bus.a), 32'h05);
    check("estado_b", 32'(bus.estado), 32'd1);
    press_chk(8'h03, "pulse_b");
    check("load_b", 32'(bus.b), 32'h03);
    check("estado_op", 32'(bus.estado), 32'd2);
    exp_q.push_back({8'h08, 1'b0, 1'b0});
    bus.entrada = 8'h20;
    bus.boton = 1'b1;
    wait_pulso(found);
    @(posedge clk); #1;
    check("calc_estado", 32'(bus.estado), 32'd3);
    check("calc_valido", 32'(bus.valido), 32'd0);
    @(posedge clk); #1;
    check("lat_valido", 32'(bus.valido), 32'd1);
    check("mostrar_estado", 32'(bus.estado), 32'd4);
    check("load_op", 32'(bus.op), 32'h20);
    repeat (4) @(posedge clk);
    #1 bus.boton = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("mostrar_hold", 32'(bus.estado), 32'd4);

    // chained operation from MOSTRAR
    press_chk(8'h10, "pulse_chain");
    check("chain_valido", 32'(bus.valido), 32'd0);
    check("chain_a", 32'(bus.a), 32'h10);
    check("chain_estado", 32'(bus.estado), 32'd1);
    check("chain_rdo", 32'(bus.rdo), 32'h08);

    // carry and zero, upper entrada bits ignored for op
    cancel();
    check("cancel_estado", 32'(bus.estado), 32'd0);
    check("cancel_a", 32'(bus.a), 32'd0);
    press_chk(8'hFF, "pulse_ff");
    press_chk(8'h01, "pulse_01");
    exp_q.push_back({8'h00, 1'b1, 1'b1});
    press_chk(8'hC5, "pulse_op2");
    check("op_trunc", 32'(bus.op), 32'h05);
    check("cz_valido", 32'(bus.valido), 32'd1);

    // debounce: short glitch then long hold
    cancel();
    p0 = pulse_cnt;
    @(posedge clk); #1 bus.boton = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.boton = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch_estado", 32'(bus.estado), 32'd0);
    bus.entrada = 8'h55;
    bus.boton = 1'b1;
    edge_at = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (dut.pulso_q && edge_at == 0) edge_at = e;
    end
    repeat (30) @(posedge clk);
    #1 bus.boton = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("hold_edge", 32'(edge_at), 32'd6);
    check("hold_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("hold_a", 32'(bus.a), 32'h55);

    // abort coincident with the op strobe
    press_chk(8'h22, "pulse_b2");
    check("abort_pre", 32'(bus.estado), 32'd2);
    bus.entrada = 8'h3F;
    bus.boton = 1'b1;
    wait_pulso(found);
    bus.cancelar = 1'b1;
    @(posedge clk); #1;
    bus.cancelar = 1'b0;
    check("abort_estado", 32'(bus.estado), 32'd0);
    check("abort_op", 32'(bus.op), 32'd0);
    check("abort_data", {bus.a, bus.b, bus.rdo, 6'b0, bus.carry, bus.zero}, 32'd0);
    check("abort_valido", 32'(bus.valido), 32'd0);
    repeat (4) @(posedge clk);
    #1 bus.boton = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("abort_hold", 32'(bus.estado), 32'd0);

    // async reset in MOSTRAR with the button held through it
    press_chk(8'h30, "pulse_30");
    press_chk(8'h50, "pulse_50");
    exp_q.push_back({8'h80, 1'b0, 1'b0});
    press_chk(8'h01, "pulse_op3");
    check("pre_rst_estado", 32'(bus.estado), 32'd4);
    @(negedge clk);
    bus.boton = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_estado", 32'(bus.estado), 32'd0);
    check("arst_valido", 32'(bus.valido), 32'd0);
    check("arst_data", {bus.a, bus.b, bus.rdo, 6'b0, bus.carry, bus.zero}, 32'd0);
    p0 = pulse_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("arst_held_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("arst_held_estado", 32'(bus.estado), 32'd0);
    bus.boton = 1'b0;
    repeat (6) @(posedge clk);
    press_chk(8'h07, "pulse_repress");
    check("repress_a", 32'(bus.a), 32'h07);
    check("repress_estado", 32'(bus.estado), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end
endmodule
